// File: rtl/map_loader.sv
// Streams one puzzle (solution digit, visibility flag, shown digit) from the constant
// map bank into the board storage, one cell per valid/ready beat.
module map_loader #(
   parameter int NUM_PUZZLES = 8,
   parameter int CELLS       = 81
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_PUZZLES*CELLS*4-1:0]       maps_easy,
   input  logic [NUM_PUZZLES*CELLS*4-1:0]       maps_hard,
   input  logic [NUM_PUZZLES*CELLS*2-1:0]       visibilities_easy,
   input  logic [NUM_PUZZLES*CELLS*2-1:0]       visibilities_hard,
   input  logic                                 difficulty,
   input  logic                                 load_req,
   output logic                                 wr_valid,
   input  logic                                 wr_ready,
   output logic [$clog2(CELLS)-1:0]             wr_addr,
   output logic [3:0]                           wr_solution,
   output logic [3:0]                           wr_value,
   output logic                                 wr_fixed,
   output logic [$clog2(NUM_PUZZLES)-1:0]       puzzle_idx,
   output logic                                 busy,
   output logic                                 done
);

   localparam int IW        = $clog2(NUM_PUZZLES);
   localparam int AW        = $clog2(CELLS);
   localparam int SOL_SLICE = CELLS * 4;
   localparam int VIS_SLICE = CELLS * 2;
   localparam int SOL_TOT   = NUM_PUZZLES * SOL_SLICE;
   localparam int VIS_TOT   = NUM_PUZZLES * VIS_SLICE;
   localparam int SH_W      = $clog2(SOL_TOT);
   localparam logic [AW-1:0] LAST_ADDR = AW'(CELLS - 1);

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [IW-1:0]   sel_q;
   logic [IW-1:0]   idx_q, idx_d;
   logic            diff_q, diff_d;

   logic [SOL_TOT-1:0] sol_bus;
   logic [VIS_TOT-1:0] vis_bus;
   logic [SH_W-1:0]    sol_sh, vis_sh;
   logic [3:0]         digit;
   logic               fixed_bit;
   logic               loading;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         sel_q   <= '0;
         idx_q   <= '0;
         diff_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         idx_q   <= idx_d;
         diff_q  <= diff_d;
         // Free-running puzzle selector only advances while waiting for a request
         if (state_q == IDLE)
            sel_q <= sel_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      idx_d   = idx_q;
      diff_d  = diff_q;
      case (state_q)
         IDLE: begin
            if (load_req) begin
               diff_d  = difficulty;
               idx_d   = sel_q;
               addr_d  = '0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (wr_ready) begin
               if (addr_q == LAST_ADDR)
                  state_d = DONE;
               else
                  addr_d = addr_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Puzzle 0 / cell 0 sit at the MSB end, so shift distances count from the far end
   always_comb begin
      sol_bus   = diff_q ? maps_hard : maps_easy;
      vis_bus   = diff_q ? visibilities_hard : visibilities_easy;
      sol_sh    = SH_W'(SOL_SLICE * (NUM_PUZZLES - 1 - int'(idx_q))
                        + 4 * (CELLS - 1 - int'(addr_q)));
      vis_sh    = SH_W'(VIS_SLICE * (NUM_PUZZLES - 1 - int'(idx_q))
                        + 2 * (CELLS - 1 - int'(addr_q)) + 1);
      digit     = 4'(sol_bus >> sol_sh);
      fixed_bit = 1'(vis_bus >> vis_sh);
   end

   assign loading     = (state_q == LOAD);
   assign wr_valid    = loading;
   assign wr_addr     = loading ? addr_q : '0;
   assign wr_solution = loading ? digit : '0;
   assign wr_fixed    = loading & fixed_bit;
   assign wr_value    = (loading && fixed_bit) ? digit : '0;
   assign puzzle_idx  = idx_q;
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);

endmodule

// File: tb/tb_map_loader.sv
// Bench for map_loader: random bank and ready stalls, checked cell by cell against
// a flat-array model of the puzzle bank and the request/selector timing rules.
module tb_map_loader;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [2591:0] maps_easy, maps_hard;
   logic [1295:0] visibilities_easy, visibilities_hard;
   logic          difficulty, load_req, wr_ready;
   logic          wr_valid, wr_fixed, busy, done;
   logic [6:0]    wr_addr;
   logic [3:0]    wr_solution, wr_value;
   logic [2:0]    puzzle_idx;

   map_loader dut (
      .clk(clk), .rst_n(rst_n),
      .maps_easy(maps_easy), .maps_hard(maps_hard),
      .visibilities_easy(visibilities_easy), .visibilities_hard(visibilities_hard),
      .difficulty(difficulty), .load_req(load_req),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
      .wr_solution(wr_solution), .wr_value(wr_value), .wr_fixed(wr_fixed),
      .puzzle_idx(puzzle_idx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Bank model, flat index d*648 + p*81 + c
   int sol_m [1296];
   bit vis_m [1296];
   int lit_sol [2][9] = '{'{3,2,9,4,1,8,5,7,6}, '{2,6,7,4,3,9,1,8,5}};
   int lit_val [2][9] = '{'{3,2,9,4,0,8,5,7,6}, '{2,6,0,4,3,9,0,8,5}};

   int n_tests = 0;
   int n_fail  = 0;
   int sel_model = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic build_bank();
      for (int i = 0; i < 1296; i++) begin
         sol_m[i] = int'($urandom_range(1, 9));
         vis_m[i] = 1'($urandom);
      end
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < 9; c++) begin
            sol_m[d*648 + c] = lit_sol[d][c];
            vis_m[d*648 + c] = (lit_val[d][c] != 0);
         end
      maps_easy = '0; maps_hard = '0; visibilities_easy = '0; visibilities_hard = '0;
      // Shifting in cell by cell leaves puzzle 0 / cell 0 at the MSB end
      for (int i = 0; i < 648; i++) begin
         maps_easy = (maps_easy << 4) | 2592'(sol_m[i]);
         maps_hard = (maps_hard << 4) | 2592'(sol_m[648 + i]);
         visibilities_easy = (visibilities_easy << 2) | 1296'({vis_m[i], 1'($urandom)});
         visibilities_hard = (visibilities_hard << 2) | 1296'({vis_m[648 + i], 1'($urandom)});
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; load_req = 1'b0;
      @(posedge clk); #1;
      check("rst_valid", int'(wr_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_idx", int'(puzzle_idx), 0);
      sel_model = 0;
      rst_n = 1'b1;
   endtask

   task automatic idle(input int k);
      load_req = 1'b0;
      repeat (k) begin
         @(posedge clk);
         sel_model = (sel_model + 1) % 8;
         #1;
      end
      check("idle_busy", int'(busy), 0);
   endtask

   // Called just after an edge with the DUT idle; the request goes out on the next edge.
   task automatic do_load(input int d, input int ready_pct, input bit pulse, input int rst_at);
      int  exp_idx, exp_addr, base, cyc, es;
      bit  ready, finished;
      exp_idx  = sel_model;
      load_req = 1'b1; difficulty = 1'(d);
      @(posedge clk);
      sel_model = (sel_model + 1) % 8;
      #1;
      load_req = 1'b0; difficulty = 1'($urandom);
      check("load_idx", int'(puzzle_idx), exp_idx);
      base = d*648 + exp_idx*81;
      exp_addr = 0; finished = 1'b0;
      for (cyc = 1; cyc < 400 && !finished; cyc++) begin
         if (exp_addr < 81) begin
            es = sol_m[base + exp_addr];
            check("beat_valid", int'(wr_valid), 1);
            check("beat_busy", int'(busy), 1);
            check("beat_done", int'(done), 0);
            check("beat_addr", int'(wr_addr), exp_addr);
            check("beat_sol", int'(wr_solution), es);
            check("beat_fixed", int'(wr_fixed), int'(vis_m[base + exp_addr]));
            check("beat_value", int'(wr_value), vis_m[base + exp_addr] ? es : 0);
            if (exp_idx == 0 && exp_addr < 9) begin
               check("lit_sol", int'(wr_solution), lit_sol[d][exp_addr]);
               check("lit_value", int'(wr_value), lit_val[d][exp_addr]);
            end
            if (exp_addr == rst_at) begin
               rst_n = 1'b0; wr_ready = 1'($urandom);
               @(posedge clk); #1;
               check("midrst_valid", int'(wr_valid), 0);
               check("midrst_busy", int'(busy), 0);
               check("midrst_idx", int'(puzzle_idx), 0);
               check("midrst_done", int'(done), 0);
               rst_n = 1'b1; sel_model = 0;
               return;
            end
            ready    = ($urandom_range(0, 99) < 32'(ready_pct));
            wr_ready = ready;
            load_req = pulse && (cyc == 20);
            difficulty = 1'($urandom);
            @(posedge clk); #1;
            load_req = 1'b0;
            if (ready) exp_addr++;
         end else begin
            check("done_pulse", int'(done), 1);
            check("done_valid", int'(wr_valid), 0);
            check("done_busy", int'(busy), 1);
            if (ready_pct >= 100) check("done_cycle", cyc, 82);
            load_req = pulse;
            @(posedge clk); #1;
            load_req = 1'b0;
            check("post_done", int'(done), 0);
            check("post_busy", int'(busy), 0);
            check("post_valid", int'(wr_valid), 0);
            check("post_idx", int'(puzzle_idx), exp_idx);
            finished = 1'b1;
         end
      end
      if (!finished) check("load_timeout", 0, 1);
   endtask

   initial begin
      rst_n = 1'b0; load_req = 1'b0; difficulty = 1'b0; wr_ready = 1'b0;
      build_bank();
      repeat (3) @(posedge clk);
      #1;
      check("init_valid", int'(wr_valid), 0);
      check("init_busy", int'(busy), 0);
      check("init_done", int'(done), 0);
      check("init_idx", int'(puzzle_idx), 0);
      check("init_addr", int'(wr_addr), 0);
      check("init_sol", int'(wr_solution), 0);
      rst_n = 1'b1; sel_model = 0;

      do_load(0, 100, 1'b0, -1);
      do_reset();
      do_load(1, 100, 1'b0, -1);

      for (int t = 0; t < 6; t++) begin
         idle(int'($urandom_range(0, 11)));
         do_load(int'($urandom_range(0, 1)), int'($urandom_range(40, 90)), 1'b1, -1);
      end

      idle(int'($urandom_range(1, 5)));
      do_load(0, 70, 1'b0, 40);
      do_load(1, 60, 1'b0, -1);
      idle(3);
      do_load(0, 100, 1'b1, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
